// File: rtl/cla_pipe_addsub.sv
// cla_pipe_addsub: pipelined WIDTH-bit add/subtract built from SEGS carry-lookahead segments
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   en        pipeline advance, 0 freezes every register
//   in_valid  operands valid this cycle (sampled when en=1)
//   sub       0: a+b+c_in, 1: a-b-c_in (c_in is borrow-in)
//   a, b      unsigned WIDTH-bit operands
//   c_in      carry-in / borrow-in
//   out_valid sum/c_out hold a new result
//   sum       result modulo 2^WIDTH
//   c_out     add: carry out; sub: 1 = no borrow
module cla_pipe_addsub #(
   parameter int WIDTH = 192,
   parameter int SEGS  = 3,
   parameter int GW    = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             in_valid,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic             out_valid,
   output logic [WIDTH-1:0] sum,
   output logic             c_out
);
   localparam int SW = WIDTH / SEGS;
   localparam int NG = SW / GW;
   logic [WIDTH-1:0] w_b;
   logic             w_ci;
   logic [SEGS-1:0]  w_vin, w_ld, w_co, r_vld, r_c;
   // subtraction as a + ~b + ~borrow, so sub only matters at the input
   assign w_b       = b ^ {WIDTH{sub}};
   assign w_ci      = c_in ^ sub;
   assign w_ld      = w_vin & {SEGS{en}};
   assign out_valid = r_vld[SEGS-1];
   assign c_out     = r_c[SEGS-1];
   // one segment: group G/P, lookahead across groups, local carries inside each group
   function automatic logic [SW:0] cla(input logic [SW-1:0] x, input logic [SW-1:0] y, input logic ci);
      logic [SW-1:0] g, p, c;
      logic [NG-1:0] gg, gp;
      logic [NG:0]   gc;
      logic          acc, pp;
      g  = x & y;
      p  = x ^ y;
      c  = '0;
      gc = '0;
      for (int i = 0; i < NG; i++) begin
         gg[i] = 1'b0;
         gp[i] = 1'b1;
         for (int j = 0; j < GW; j++) begin
            gg[i] = g[i*GW+j] | (p[i*GW+j] & gg[i]);
            gp[i] = gp[i] & p[i*GW+j];
         end
      end
      gc[0] = ci;
      // flattened lookahead: each group carry is a sum of products, not a ripple
      for (int i = 0; i < NG; i++) begin
         acc = gg[i];
         pp  = gp[i];
         for (int j = i - 1; j >= 0; j--) begin
            acc = acc | (pp & gg[j]);
            pp  = pp & gp[j];
         end
         gc[i+1] = acc | (pp & ci);
      end
      for (int i = 0; i < NG; i++) begin
         acc = gc[i];
         for (int j = 0; j < GW; j++) begin
            c[i*GW+j] = acc;
            acc = g[i*GW+j] | (p[i*GW+j] & acc);
         end
      end
      return {gc[NG], p ^ c};
   endfunction
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_vld <= '0;
         r_c   <= '0;
      end else begin
         if (en) r_vld <= w_vin;
         for (int k = 0; k < SEGS; k++)
            if (w_ld[k]) r_c[k] <= w_co[k];
      end
   for (genvar k = 0; k < SEGS; k++) begin : g_stg
      logic [SW-1:0] w_x, w_y, w_s;
      logic          w_cin;
      // deskew chain; entry 0 is the stage result register
      logic [SW-1:0] r_ds [SEGS-k];
      if (k == 0) begin : g_first
         assign w_vin[0] = in_valid;
         assign w_x      = a[SW-1:0];
         assign w_y      = w_b[SW-1:0];
         assign w_cin    = w_ci;
      end else begin : g_rest
         // input skew: slice k waits k ranks so it meets the carry of stage k-1
         logic [SW-1:0] r_sa [k];
         logic [SW-1:0] r_sb [k];
         assign w_vin[k] = r_vld[k-1];
         assign w_x      = r_sa[k-1];
         assign w_y      = r_sb[k-1];
         assign w_cin    = r_c[k-1];
         always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) begin
               for (int m = 0; m < k; m++) begin
                  r_sa[m] <= '0;
                  r_sb[m] <= '0;
               end
            end else begin
               if (w_ld[0]) begin
                  r_sa[0] <= a[k*SW +: SW];
                  r_sb[0] <= w_b[k*SW +: SW];
               end
               for (int m = 1; m < k; m++)
                  if (w_ld[m]) begin
                     r_sa[m] <= r_sa[m-1];
                     r_sb[m] <= r_sb[m-1];
                  end
            end
      end
      assign {w_co[k], w_s} = cla(w_x, w_y, w_cin);
      always_ff @(posedge clk or negedge rst_n)
         if (!rst_n) begin
            for (int m = 0; m < SEGS - k; m++) r_ds[m] <= '0;
         end else begin
            if (w_ld[k]) r_ds[0] <= w_s;
            for (int m = 1; m < SEGS - k; m++)
               if (w_ld[k+m]) r_ds[m] <= r_ds[m-1];
         end
      assign sum[k*SW +: SW] = r_ds[SEGS-1-k];
   end
endmodule

// File: tb/tb_cla_pipe_addsub.sv
// tb_cla_pipe_addsub: randomized bench for three cla_pipe_addsub configurations against an arithmetic model
module tb_cla_pipe_addsub;
   logic         clk = 0, rst_n = 0, en = 0, in_valid = 0, sub = 0, c_in = 0;
   logic [191:0] a = '0, b = '0;
   logic         ov0, ov1, ov2, co0, co1, co2;
   logic [191:0] s0, s1, s2;
   logic [193:0] got [3];
   int           lat [3] = '{3, 1, 4};
   logic         hist_v [4096];
   logic [192:0] hist_r [4096];
   int           ecnt = 0, rbase = 0, n_cmp = 0, n_err = 0;
   always #5 clk = ~clk;
   cla_pipe_addsub #(.WIDTH(192), .SEGS(3), .GW(4)) u_d0 (.clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid),
      .sub(sub), .a(a), .b(b), .c_in(c_in), .out_valid(ov0), .sum(s0), .c_out(co0));
   cla_pipe_addsub #(.WIDTH(192), .SEGS(1), .GW(8)) u_d1 (.clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid),
      .sub(sub), .a(a), .b(b), .c_in(c_in), .out_valid(ov1), .sum(s1), .c_out(co1));
   cla_pipe_addsub #(.WIDTH(192), .SEGS(4), .GW(2)) u_d2 (.clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid),
      .sub(sub), .a(a), .b(b), .c_in(c_in), .out_valid(ov2), .sum(s2), .c_out(co2));
   assign got[0] = {ov0, co0, s0};
   assign got[1] = {ov1, co1, s1};
   assign got[2] = {ov2, co2, s2};
   function automatic logic [192:0] gold(input logic [191:0] x, input logic [191:0] y, input logic ci, input logic s);
      logic [193:0] t;
      if (s) begin
         t = {2'b0, x} - {2'b0, y} - 194'(ci);
         return {~t[193], t[191:0]};
      end
      t = {2'b0, x} + {2'b0, y} + 194'(ci);
      return {t[192], t[191:0]};
   endfunction
   // expected {out_valid, c_out, sum}: op accepted at en-cycle i shows when lat more en-cycles have elapsed
   function automatic logic [193:0] expv(input int l);
      int   idx;
      logic v;
      idx = ecnt - l;
      v = (idx >= rbase) ? hist_v[idx] : 1'b0;
      for (int i = idx; i >= rbase; i--)
         if (hist_v[i]) return {v, hist_r[i]};
      return {v, 193'b0};
   endfunction
   function automatic logic [191:0] rnd192();
      logic [191:0] r;
      r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      case ($urandom_range(0, 7))
         0: r = '1;
         1: r = '0;
         2: r = {128'b0, {64{1'b1}}};
         3: r = {64'b0, {128{1'b1}}};
         default: ;
      endcase
      return r;
   endfunction
   task automatic cyc();
      if (en && rst_n) begin
         hist_v[ecnt] = in_valid;
         hist_r[ecnt] = gold(a, b, c_in, sub);
         ecnt++;
      end
      @(posedge clk);
      #2;
   endtask
   task automatic drive(input logic v, input logic s, input logic [191:0] x, input logic [191:0] y, input logic ci);
      in_valid = v;
      sub = s;
      a = x;
      b = y;
      c_in = ci;
   endtask
   task automatic test_reset();
      logic [193:0] e;
      #3;
      for (int d = 0; d < 3; d++) begin
         n_cmp++;
         if (got[d] !== 194'b0) begin
            n_err++;
            $display("FAIL reset_init dut%0d: got %h want 0", d, got[d]);
         end
      end
      cyc();
      rst_n = 1;
      en = 1;
      drive(1, 0, rnd192(), rnd192(), 1);
      cyc();
      drive(1, 1, rnd192(), rnd192(), 0);
      cyc();
      drive(0, 0, '0, '0, 0);
      rst_n = 0;
      rbase = ecnt;
      #1;
      for (int d = 0; d < 3; d++) begin
         n_cmp++;
         if (got[d] !== 194'b0) begin
            n_err++;
            $display("FAIL reset_mid dut%0d: got %h want 0", d, got[d]);
         end
      end
      #1;
      cyc();
      cyc();
      rst_n = 1;
      drive(1, 0, rnd192(), rnd192(), 0);
      for (int n = 0; n < 6; n++) begin
         cyc();
         drive(0, 0, rnd192(), rnd192(), 1);
         for (int d = 0; d < 3; d++) begin
            e = expv(lat[d]);
            n_cmp++;
            if (got[d] !== e) begin
               n_err++;
               $display("FAIL reset_after dut%0d: got v=%b c=%b sum=%h, want v=%b c=%b sum=%h", d,
                  got[d][193], got[d][192], got[d][191:0], e[193], e[192], e[191:0]);
            end
         end
      end
   endtask
   task automatic test_directed(input string nm, input logic s, input logic [191:0] x, input logic [191:0] y,
                                input logic ci, input logic [192:0] want);
      logic [193:0] e;
      drive(1, s, x, y, ci);
      n_cmp++;
      if (gold(x, y, ci, s) !== want) begin
         n_err++;
         $display("FAIL %s_model: got %h want %h", nm, gold(x, y, ci, s), want);
      end
      for (int n = 0; n < 6; n++) begin
         cyc();
         drive(0, 0, rnd192(), rnd192(), 0);
         for (int d = 0; d < 3; d++) begin
            e = expv(lat[d]);
            if (n == lat[d] - 1) e = {1'b1, want};
            n_cmp++;
            if (got[d] !== e) begin
               n_err++;
               $display("FAIL %s dut%0d cyc%0d: got v=%b c=%b sum=%h, want v=%b c=%b sum=%h", nm, d, n,
                  got[d][193], got[d][192], got[d][191:0], e[193], e[192], e[191:0]);
            end
         end
      end
   endtask
   task automatic test_interleave();
      logic [193:0] e;
      logic [7:0]   pat;
      pat = 8'b1011_1011;
      for (int n = 0; n < 14; n++) begin
         if (n < 8) drive(pat[7-n], n[0], rnd192(), rnd192(), 1'($urandom));
         else drive(0, 0, rnd192(), rnd192(), 0);
         cyc();
         for (int d = 0; d < 3; d++) begin
            e = expv(lat[d]);
            n_cmp++;
            if (got[d] !== e) begin
               n_err++;
               $display("FAIL interleave dut%0d cyc%0d: got v=%b c=%b sum=%h, want v=%b c=%b sum=%h", d, n,
                  got[d][193], got[d][192], got[d][191:0], e[193], e[192], e[191:0]);
            end
         end
      end
   endtask
   task automatic test_stall();
      logic [193:0] e;
      drive(1, 1, rnd192(), rnd192(), 1);
      for (int n = 0; n < 10; n++) begin
         cyc();
         en = (n >= 4) ? 1'b1 : 1'b0;
         drive(n < 4, 1'($urandom), rnd192(), rnd192(), 1'($urandom));
         if (n >= 4) in_valid = 0;
         for (int d = 0; d < 3; d++) begin
            e = expv(lat[d]);
            n_cmp++;
            if (got[d] !== e) begin
               n_err++;
               $display("FAIL stall dut%0d cyc%0d: got v=%b c=%b sum=%h, want v=%b c=%b sum=%h", d, n,
                  got[d][193], got[d][192], got[d][191:0], e[193], e[192], e[191:0]);
            end
         end
      end
      en = 1;
   endtask
   task automatic test_random();
      logic [193:0] e;
      for (int n = 0; n < 300; n++) begin
         en = ($urandom_range(0, 4) != 0);
         drive(1'($urandom), 1'($urandom), rnd192(), rnd192(), 1'($urandom));
         if (n >= 290) begin
            en = 1;
            in_valid = 0;
         end
         cyc();
         for (int d = 0; d < 3; d++) begin
            e = expv(lat[d]);
            n_cmp++;
            if (got[d] !== e) begin
               n_err++;
               $display("FAIL random dut%0d cyc%0d: got v=%b c=%b sum=%h, want v=%b c=%b sum=%h", d, n,
                  got[d][193], got[d][192], got[d][191:0], e[193], e[192], e[191:0]);
            end
         end
      end
   endtask
   initial begin
      for (int i = 0; i < 4096; i++) begin
         hist_v[i] = 1'b0;
         hist_r[i] = '0;
      end
      test_reset();
      test_directed("full_carry", 0, '1, '0, 1, {1'b1, 192'b0});
      test_directed("seg_boundary", 0, {128'b0, {64{1'b1}}}, 192'd1, 0, {1'b0, 127'b0, 1'b1, 64'b0});
      test_directed("sub_borrow", 1, 192'd5, 192'd7, 0, {1'b0, {191{1'b1}}, 1'b0});
      test_directed("sub_noborrow", 1, 192'd7, 192'd5, 1, {1'b1, 192'd1});
      test_interleave();
      test_stall();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
